// File: rtl/wdg_core.sv
// Two-stage watchdog: counts rising edges of a slow time base, barks after bark_limit
// ticks without a kick, then bites after a further bite_limit ticks (sticky until reset).
module wdg_core #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 wdg_tick,
    input  logic                 en,
    input  logic                 kick,
    input  logic [CNT_WIDTH-1:0] bark_limit,
    input  logic [CNT_WIDTH-1:0] bite_limit,
    output logic                 bark,
    output logic                 bite,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        StDisabled = 2'd0,
        StRun      = 2'd1,
        StBarked   = 2'd2,
        StBitten   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 bark_q, bark_d;
    logic                 bite_q, bite_d;
    logic                 tick_q;

    logic                 tick_p;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 bark_exp;
    logic                 bite_exp;

    assign tick_p  = wdg_tick & ~tick_q;
    // One extra bit so cnt+1 never wraps when compared against a full-scale limit.
    assign cnt_inc  = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign bark_exp = tick_p && (cnt_inc >= {1'b0, bark_limit});
    assign bite_exp = tick_p && (cnt_inc >= {1'b0, bite_limit});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bark_d  = bark_q;
        bite_d  = bite_q;
        unique case (state_q)
            StDisabled: begin
                cnt_d  = '0;
                bark_d = 1'b0;
                bite_d = 1'b0;
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StDisabled;
                    cnt_d   = '0;
                end else if (kick) begin
                    cnt_d = '0;
                end else if (bark_exp) begin
                    state_d = StBarked;
                    cnt_d   = '0;
                    bark_d  = 1'b1;
                end else if (tick_p) begin
                    cnt_d = cnt_inc[CNT_WIDTH-1:0];
                end
            end
            StBarked: begin
                if (!en) begin
                    state_d = StDisabled;
                    cnt_d   = '0;
                    bark_d  = 1'b0;
                end else if (kick) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    bark_d  = 1'b0;
                end else if (bite_exp) begin
                    state_d = StBitten;
                    cnt_d   = '0;
                    bite_d  = 1'b1;
                end else if (tick_p) begin
                    cnt_d = cnt_inc[CNT_WIDTH-1:0];
                end
            end
            StBitten: begin
                bark_d = 1'b1;
                bite_d = 1'b1;
            end
            default: begin
                state_d = StDisabled;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StDisabled;
            cnt_q   <= '0;
            bark_q  <= 1'b0;
            bite_q  <= 1'b0;
            tick_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bark_q  <= bark_d;
            bite_q  <= bite_d;
            tick_q  <= wdg_tick;
        end
    end

    assign bark    = bark_q;
    assign bite    = bite_q;
    assign cnt_o   = cnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_wdg_core.sv
// Directed bench for wdg_core: a behavioural watchdog model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_wdg_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         wdg_tick = 1'b0;
    logic         en = 1'b0;
    logic         kick = 1'b0;
    logic [W-1:0] bark_limit = '0;
    logic [W-1:0] bite_limit = '0;
    logic         bark, bite;
    logic [W-1:0] cnt_o;
    logic [1:0]   state_o;

    int total = 0;
    int bad = 0;

    wdg_core #(.CNT_WIDTH(W)) dut (
        .clk(clk), .res(res), .wdg_tick(wdg_tick), .en(en), .kick(kick),
        .bark_limit(bark_limit), .bite_limit(bite_limit),
        .bark(bark), .bite(bite), .cnt_o(cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain integers, stage held as a small number.
    int m_stage;  // 0 disabled, 1 running, 2 barked, 3 bitten
    int m_cnt;
    int m_prev_tick;
    bit m_valid = 0;

    always @(posedge clk) begin
        bit t;
        t = (wdg_tick == 1'b1) && (m_prev_tick == 0);
        if (res) begin
            m_stage = 0;
            m_cnt = 0;
            m_prev_tick = 1;
        end else begin
            m_prev_tick = int'(wdg_tick);
            if (m_stage == 0) begin
                m_cnt = 0;
                if (en) m_stage = 1;
            end else if (m_stage == 1 || m_stage == 2) begin
                int lim;
                lim = (m_stage == 1) ? int'(bark_limit) : int'(bite_limit);
                if (!en) begin
                    m_stage = 0;
                    m_cnt = 0;
                end else if (kick) begin
                    m_stage = 1;
                    m_cnt = 0;
                end else if (t && (m_cnt + 1 >= lim)) begin
                    m_stage = m_stage + 1;
                    m_cnt = 0;
                end else if (t) begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        m_valid = 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state", int'(state_o), m_stage);
            check("model_cnt", int'(cnt_o), m_cnt);
            check("model_bark", int'(bark), (m_stage >= 2) ? 1 : 0);
            check("model_bite", int'(bite), (m_stage == 3) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick period of 8 clocks; optional kick on the tick's rising cycle.
    task automatic tick8(input bit with_kick);
        wdg_tick = 1'b1;
        kick = with_kick;
        cyc(1);
        kick = 1'b0;
        cyc(3);
        wdg_tick = 1'b0;
        cyc(4);
    endtask

    task automatic pins(input string tag, input int st, input int cn, input int bk, input int bt);
        check({tag, "_state"}, int'(state_o), st);
        check({tag, "_cnt"}, int'(cnt_o), cn);
        check({tag, "_bark"}, int'(bark), bk);
        check({tag, "_bite"}, int'(bite), bt);
    endtask

    initial begin
        cyc(2);
        pins("reset", 0, 0, 0, 0);

        // Scenario 1: bark on 4th tick, bite on 3rd tick after.
        bark_limit = 16'd4;
        bite_limit = 16'd3;
        res = 1'b0;
        en = 1'b1;
        cyc(1);
        pins("s1_run", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick8(1'b0);
        pins("s1_3ticks", 1, 3, 0, 0);
        tick8(1'b0);
        pins("s1_bark", 2, 0, 1, 0);
        tick8(1'b0);
        tick8(1'b0);
        pins("s1_pre_bite", 2, 2, 1, 0);
        tick8(1'b0);
        pins("s1_bite", 3, 0, 1, 1);

        // Scenario 5: BITTEN ignores en/kick; only res exits.
        en = 1'b0;
        kick = 1'b1;
        cyc(3);
        kick = 1'b0;
        pins("s5_sticky", 3, 0, 1, 1);
        res = 1'b1;
        cyc(1);
        res = 1'b0;
        pins("s5_reset", 0, 0, 0, 0);

        // Scenario 2: kick coincident with every 3rd tick keeps cnt <= 2.
        en = 1'b1;
        cyc(1);
        for (int i = 1; i <= 100; i++) begin
            tick8(i % 3 == 0);
            if (i % 10 == 0) begin
                check("s2_cnt_le2", int'(cnt_o <= 16'd2), 1);
                check("s2_no_bark", int'(bark), 0);
            end
        end
        pins("s2_end", 1, 1, 0, 0);

        // Scenario 3: kick in BARKED with cnt=1.
        kick = 1'b1;
        cyc(1);
        kick = 1'b0;
        for (int i = 0; i < 4; i++) tick8(1'b0);
        pins("s3_barked", 2, 0, 1, 0);
        tick8(1'b0);
        pins("s3_cnt1", 2, 1, 1, 0);
        kick = 1'b1;
        cyc(1);
        kick = 1'b0;
        pins("s3_kicked", 1, 0, 0, 0);

        // Scenario 4: kick beats a same-cycle tick at cnt=3.
        for (int i = 0; i < 3; i++) tick8(1'b0);
        pins("s4_cnt3", 1, 3, 0, 0);
        tick8(1'b1);
        pins("s4_kick_tick", 1, 0, 0, 0);

        // Live limit: lowering bark_limit below cnt expires on the next tick.
        tick8(1'b0);
        tick8(1'b0);
        bark_limit = 16'd1;
        tick8(1'b0);
        pins("live_limit", 2, 0, 1, 0);
        en = 1'b0;
        cyc(1);
        pins("disable", 0, 0, 0, 0);

        // Scenario 6: bark_limit=0, wdg_tick held high through reset release.
        bark_limit = 16'd0;
        wdg_tick = 1'b1;
        res = 1'b1;
        cyc(2);
        res = 1'b0;
        en = 1'b1;
        cyc(3);
        pins("s6_held_high", 1, 0, 0, 0);
        wdg_tick = 1'b0;
        cyc(2);
        wdg_tick = 1'b1;
        cyc(1);
        pins("s6_first_tick", 2, 0, 1, 0);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
